// File: rtl/tdm_demux_8ch.sv
// tdm_demux_8ch: recovers 8 channels from a slot-strobed TDM stream, checks
// slot-0 sync alignment and emits each complete frame as a parallel word.
`default_nettype none

module tdm_demux_8ch #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  input  logic            frame_sync,
  input  logic [DW-1:0]   din,
  output logic [2:0]      slot,
  output logic [8*DW-1:0] chan,
  output logic            frame_valid,
  output logic            sync_err,
  output logic [7:0]      frame_cnt
);

  typedef enum logic [0:0] {S_HUNT = 1'b0, S_RUN = 1'b1} state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_slot, w_slot;
  logic [7*DW-1:0]   r_shadow, w_shadow;
  logic [8*DW-1:0]   r_chan, w_chan;
  logic [7:0]        r_cnt, w_cnt;
  logic              r_fv, w_fv;
  logic              r_se, w_se;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_HUNT;
      r_slot   <= 3'd0;
      r_shadow <= '0;
      r_chan   <= '0;
      r_cnt    <= 8'd0;
      r_fv     <= 1'b0;
      r_se     <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_slot   <= w_slot;
      r_shadow <= w_shadow;
      r_chan   <= w_chan;
      r_cnt    <= w_cnt;
      r_fv     <= w_fv;
      r_se     <= w_se;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_slot   = r_slot;
    w_shadow = r_shadow;
    w_chan   = r_chan;
    w_cnt    = r_cnt;
    w_fv     = 1'b0;
    w_se     = 1'b0;
    if (din_valid) begin
      if (r_state == S_HUNT) begin
        if (frame_sync) begin
          w_shadow[DW-1:0] = din;
          w_slot           = 3'd1;
          w_state          = S_RUN;
        end
      end else if (frame_sync) begin
        // A sync anywhere but slot 0 restarts the frame on this strobe.
        w_se             = (r_slot != 3'd0);
        w_shadow[DW-1:0] = din;
        w_slot           = 3'd1;
      end else if (r_slot == 3'd0) begin
        w_se    = 1'b1;
        w_state = S_HUNT;
      end else if (r_slot == 3'd7) begin
        w_chan = {din, r_shadow};
        w_fv   = 1'b1;
        w_cnt  = r_cnt + 8'd1;
        w_slot = 3'd0;
      end else begin
        for (int k = 1; k < 7; k++) begin
          if (r_slot == 3'(k)) w_shadow[k*DW +: DW] = din;
        end
        w_slot = r_slot + 3'd1;
      end
    end
  end

  assign slot        = r_slot;
  assign chan        = r_chan;
  assign frame_valid = r_fv;
  assign sync_err    = r_se;
  assign frame_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux_8ch.sv
// tb_tdm_demux_8ch: directed and random stimulus against a frame-level model.
`default_nettype none

module tb_tdm_demux_8ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [0:0] din = 1'b0;
  logic [2:0] slot;
  logic [7:0] chan;
  logic       frame_valid;
  logic       sync_err;
  logic [7:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: frame assembly in a plain array
  bit         m_run = 0;
  int         m_pos = 0;
  logic [7:0] m_buf = '0;
  logic [7:0] m_chan = '0;
  int         m_cnt = 0;
  bit         e_fv = 0;
  bit         e_se = 0;

  tdm_demux_8ch #(.DW(1)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .frame_sync(frame_sync),
    .din(din), .slot(slot), .chan(chan), .frame_valid(frame_valid),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".slot"}, 32'(slot), 32'(m_pos));
    chk({tag, ".chan"}, 32'(chan), 32'(m_chan));
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(e_fv));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(e_se));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_buf = '0; m_chan = '0; m_cnt = 0; e_fv = 0; e_se = 0;
  endtask

  // Drive one cycle, advance the model by the spec rules, compare after the edge.
  task automatic step(input bit v, input bit fs, input bit d, input string tag);
    din_valid = v; frame_sync = fs; din = d;
    @(posedge clk); #1;
    e_fv = 0; e_se = 0;
    if (v) begin
      if (!m_run) begin
        if (fs) begin m_buf[0] = d; m_pos = 1; m_run = 1; end
      end else if (fs) begin
        e_se = (m_pos != 0);
        m_buf[0] = d; m_pos = 1;
      end else if (m_pos == 0) begin
        e_se = 1; m_run = 0;
      end else begin
        m_buf[m_pos] = d;
        m_pos++;
        if (m_pos == 8) begin
          m_chan = m_buf; e_fv = 1; m_cnt = (m_cnt + 1) % 256; m_pos = 0;
        end
      end
    end
    chk_all(tag);
  endtask

  task automatic send_frame(input logic [7:0] val, input int maxgap, input string tag);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        int g;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int j = 0; j < g; j++) step(0, 0, 1'($urandom), {tag, ".gap"});
      end
      step(1, (k == 0), val[k], tag);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk_all("reset");
    rst = 1'b0;

    // HUNT: unsynced strobes are discarded silently
    for (int i = 0; i < 5; i++) step(1, 0, 1'($urandom), "hunt");
    send_frame(8'h13, 0, "f13");
    chk("f13.const", 32'(chan), 32'h13);

    // Back-to-back frames, then gapped
    send_frame(8'hA1, 0, "fA1");
    chk("fA1.const", 32'(chan), 32'hA1);
    send_frame(8'hA1, 3, "fA1gap");
    chk("fA1gap.cnt", 32'(frame_cnt), 32'd3);

    // Early sync after 4 slots
    for (int k = 0; k < 4; k++) step(1, (k == 0), 1'($urandom), "partial");
    send_frame(8'h02, 0, "f02");
    chk("f02.const", 32'(chan), 32'h02);

    // Missing sync at slot 0, then unsynced strobes produce nothing
    step(1, 0, 1, "nosync");
    chk("nosync.err", 32'(sync_err), 32'd1);
    for (int i = 0; i < 7; i++) step(1, 0, 1'($urandom), "nosync.hunt");

    // Async reset between slot 3 and slot 4
    send_frame(8'h5C, 0, "f5C");
    for (int k = 0; k < 4; k++) step(1, (k == 0), 1'($urandom), "prerst");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_all("asyncrst");
    @(posedge clk); #1;
    chk_all("rsthold");
    #2 rst = 1'b0;
    send_frame(8'h09, 0, "f09");
    chk("f09.const", 32'(chan), 32'h09);
    chk("f09.cnt", 32'(frame_cnt), 32'd1);

    // Random traffic with occasional misaligned syncs and gaps
    for (int i = 0; i < 3000; i++) begin
      bit v, fs;
      v  = ($urandom_range(3, 0) != 0);
      fs = (m_pos == 0) ? ($urandom_range(7, 0) != 0) : ($urandom_range(15, 0) == 0);
      step(v, fs, 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tdm_demux_8ch.md
# tdm_demux_8ch

Receive-side counterpart of the 8:1 channel multiplexer. A transmitter scans its select 0..7 and sends one slot per strobe. This block recovers the 8 channels from that serial time-division stream. It tracks slot position, checks frame alignment against a slot-0 sync marker, and presents each completed frame as a parallel word with a one-cycle valid pulse.

## Interface

Parameters:
- DW, 1, data width of one slot/channel.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- din_valid  input  1  slot strobe; din/frame_sync sampled only when high.
- frame_sync  input  1  high with the strobe that carries slot 0.
- din  input  DW  slot data.
- slot  output  3  index of the next expected slot.
- chan  output  8*DW  last complete frame; chan[k*DW +: DW] = slot k (= mux input I[k], Sel=k).
- frame_valid  output  1  one-cycle pulse when chan updates.
- sync_err  output  1  one-cycle pulse on alignment error.
- frame_cnt  output  8  count of good frames, wraps 255->0.

## Operation

- States: HUNT, RUN. Reset state is HUNT.
- Internal shadow register holds slots 0..6 of the frame in progress.
- HUNT:
  - Strobes without frame_sync are discarded silently (no sync_err).
  - A strobe with frame_sync stores din into shadow[0], sets slot=1 and goes to RUN.
- RUN, strobe at slot 0:
  - frame_sync=1: store shadow[0], slot=1.
  - frame_sync=0: pulse sync_err, discard, slot=0, go to HUNT.
- RUN, strobe at slot 1..6:
  - frame_sync=0: store shadow[slot], slot+1.
  - frame_sync=1: early sync. Pulse sync_err and drop the partial frame. Treat this strobe as slot 0 of a new frame (shadow[0]=din, slot=1) and stay in RUN.
- RUN, strobe at slot 7:
  - frame_sync=0: chan <= {din, shadow[6:0]}, frame_valid pulse, frame_cnt+1, slot=0. Stay in RUN.
  - frame_sync=1: early-sync handling as for slots 1..6; no frame output.
- No strobe: nothing changes. Gaps of any length between strobes are legal.
- chan holds its value between frames. Only a complete, error-free frame overwrites it.
- frame_cnt is modulo 256; it is not reset by sync_err.

## Timing

- Reset (async assert) forces: slot=0, chan=0, frame_valid=0, sync_err=0, frame_cnt=0, shadow=0, state=HUNT.
  - Holds while rst is high.
  - The first edge after deassertion operates normally.
- Reset mid-frame discards the partial frame; chan keeps no old data (it is 0).
- Latency: for the clk edge that samples the slot-7 strobe:
  - chan, frame_valid and frame_cnt update on that same edge.
  - frame_valid is high for exactly one cycle after it.
- sync_err is registered and asserts on the edge that samples the offending strobe, for one cycle.
- frame_valid and sync_err are never high in the same cycle.
- Back-to-back strobes every cycle sustain one frame per 8 cycles. frame_valid may pulse every 8th cycle with no dead cycle.
- slot is registered state and reflects the edge just taken. The slot-7 strobe returns it to 0 with the wrap.

## Test plan

- Basic frame, DW=1, strobes every cycle: slot bits 1,0,0,0,0,1,0,1 with frame_sync on the first → 8'hA1 appears on chan one edge after the 8th strobe; frame_valid pulses once; frame_cnt=1.
- Gapped strobes: same frame with 0-3 idle cycles inserted between strobes → chan=8'hA1, single frame_valid, nothing changes during gaps.
- HUNT: 5 strobes without sync, then a frame carrying 8'h13 (slots 1,1,0,0,1,0,0,0) with sync on slot 0 → no sync_err during the first 5 strobes; chan=8'h13.
- Early sync: good frame 8'hA1, then 4 slots, then a strobe with frame_sync → sync_err pulses and chan stays 8'hA1. The following 7 strobes completing frame 8'h02 → chan=8'h02; frame_cnt=2.
- Missing sync at slot 0 in RUN → sync_err pulses, state HUNT, and the next 7 strobes produce no frame_valid.
- Async reset asserted between slot 3 and slot 4, not at a clock edge → all outputs 0 immediately, slot=0. A full frame 8'h09 after deassertion → chan=8'h09, frame_cnt=1.
